// File: rtl/uart_frame_gen_pkg.sv
// uart_frame_gen_pkg: parity mode encodings and serializer state type
package uart_frame_gen_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_t;
endpackage

// File: rtl/uart_frame_gen_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and dropped-write pulse
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr + AW'(push);
      rptr     <= rptr + AW'(pop);
      level    <= level + LW'(push) - LW'(pop);
      overflow <= wr_en && full;
    end
  end
  // storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end
endmodule

// File: rtl/uart_frame_gen.sv
// uart_frame_gen: FIFO-fed UART serializer with configurable frame format
module uart_frame_gen
  import uart_frame_gen_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CLKS     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam int GW = GAP_CLKS > 1 ? $clog2(GAP_CLKS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CLKS - 1);
  localparam logic [GW-1:0] G_PRE  = GW'(GAP_CLKS - 2);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_frame_gen: DATA_W must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_frame_gen: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_frame_gen: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_frame_gen: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_frame_gen: STOP_BITS must be 1 or 2");
  end
  if (GAP_CLKS < 0) begin : g_bad_gap
    $error("uart_frame_gen: GAP_CLKS must be >= 0");
  end

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bcnt;
  logic [GW-1:0]       gcnt;
  logic [DATA_W-1:0]   sh, head;
  logic                par, bit_end, fin, pre_last, pop;

  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // fin marks the frame's last cycle, pre_last the one before it so frame_done can be registered
  always_comb begin
    bit_end  = cnt == C_LAST;
    fin      = GAP_CLKS == 0 ? state == S_STOP && bit_end && bcnt == S_LAST
                             : state == S_GAP && gcnt == G_LAST;
    pre_last = GAP_CLKS == 0 ? state == S_STOP && bcnt == S_LAST && cnt == C_PRE
             : GAP_CLKS == 1 ? state == S_STOP && bcnt == S_LAST && bit_end
                             : state == S_GAP && gcnt == G_PRE;
    pop      = !empty && (state == S_IDLE || fin);
  end

  // serializer: a pop always launches a start bit, so back-to-back frames have no idle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      sh         <= '0;
      par        <= 1'b0;
    end else begin
      frame_done <= pre_last;
      cnt        <= (bit_end || state == S_IDLE || state == S_GAP) ? '0 : cnt + 1'b1;
      gcnt       <= state == S_GAP ? gcnt + 1'b1 : '0;
      if (pop) begin
        sh    <= head;
        par   <= ^head ^ (PARITY == PARITY_ODD);
        tx    <= 1'b0;
        busy  <= 1'b1;
        state <= S_START;
      end else if (fin) begin
        busy  <= 1'b0;
        state <= S_IDLE;
      end else if (bit_end) begin
        case (state)
          S_START: begin
            tx    <= sh[0];
            sh    <= sh >> 1;
            bcnt  <= '0;
            state <= S_DATA;
          end
          S_DATA: begin
            if (bcnt == D_LAST) begin
              tx    <= PARITY != PARITY_NONE ? par : 1'b1;
              bcnt  <= '0;
              state <= PARITY != PARITY_NONE ? S_PAR : S_STOP;
            end else begin
              tx   <= sh[0];
              sh   <= sh >> 1;
              bcnt <= bcnt + 1'b1;
            end
          end
          S_PAR: begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
          S_STOP: begin
            if (bcnt == S_LAST) state <= S_GAP;
            else bcnt <= bcnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_gen.sv
// tb_uart_frame_gen: directed checks of frame timing, parity, gaps, overflow and reset
module tb_uart_frame_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [8:0] wr_data = '0;
  int         sel = 0;
  int         checks = 0;
  int         failures = 0;
  logic [4:0] we;
  logic       tx_v [5];
  logic       busy_v [5];
  logic       fd_v [5];
  logic       full_v [5];
  logic       empty_v [5];
  logic       ovf_v [5];
  logic [2:0] lvl_v [5];
  logic       tx_o, busy_o, fd_o, full_o, empty_o, ovf_o;
  logic [2:0] lvl_o;

  always #5 clk = ~clk;

  assign we      = wr_en ? 5'(1 << sel) : 5'b0;
  assign tx_o    = tx_v[sel];
  assign busy_o  = busy_v[sel];
  assign fd_o    = fd_v[sel];
  assign full_o  = full_v[sel];
  assign empty_o = empty_v[sel];
  assign ovf_o   = ovf_v[sel];
  assign lvl_o   = lvl_v[sel];

  uart_frame_gen u0 (
    .clk(clk), .rst(rst), .wr_en(we[0]), .wr_data(wr_data[7:0]),
    .full(full_v[0]), .empty(empty_v[0]), .level(lvl_v[0]), .overflow(ovf_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
  uart_frame_gen #(.PARITY(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(we[1]), .wr_data(wr_data[7:0]),
    .full(full_v[1]), .empty(empty_v[1]), .level(lvl_v[1]), .overflow(ovf_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
  uart_frame_gen #(.PARITY(2)) u2 (
    .clk(clk), .rst(rst), .wr_en(we[2]), .wr_data(wr_data[7:0]),
    .full(full_v[2]), .empty(empty_v[2]), .level(lvl_v[2]), .overflow(ovf_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));
  uart_frame_gen #(.STOP_BITS(2), .GAP_CLKS(4)) u3 (
    .clk(clk), .rst(rst), .wr_en(we[3]), .wr_data(wr_data[7:0]),
    .full(full_v[3]), .empty(empty_v[3]), .level(lvl_v[3]), .overflow(ovf_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(fd_v[3]));
  uart_frame_gen #(.DATA_W(9), .CLKS_PER_BIT(3)) u4 (
    .clk(clk), .rst(rst), .wr_en(we[4]), .wr_data(wr_data),
    .full(full_v[4]), .empty(empty_v[4]), .level(lvl_v[4]), .overflow(ovf_v[4]),
    .tx(tx_v[4]), .busy(busy_v[4]), .frame_done(fd_v[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic push(input logic [8:0] d);
    wr_en   = 1'b1;
    wr_data = d;
  endtask

  task automatic check_frame(input int dw, input int cpb, input int pm, input int sb,
                             input int gap, input logic [8:0] d);
    int   len;
    int   b;
    logic p;
    logic e;
    len = (1 + dw + (pm != 0 ? 1 : 0) + sb) * cpb + gap;
    p = pm == 2;
    for (int i = 0; i < dw; i++) p ^= d[i];
    for (int k = 1; k <= len; k++) begin
      tick();
      b = (k - 1) / cpb;
      e = b == 0 ? 1'b0 : b <= dw ? d[b-1] : (pm != 0 && b == dw + 1) ? p : 1'b1;
      chk($sformatf("tx[u%0d c%0d]", sel, k), tx_o, e);
      chk($sformatf("busy[u%0d c%0d]", sel, k), busy_o, 1);
      chk($sformatf("frame_done[u%0d c%0d]", sel, k), fd_o, k == len);
    end
  endtask

  initial begin
    int n;
    int lows;
    tick();
    tick();
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_frame_done", fd_o, 0);
    chk("rst_overflow", ovf_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_level", lvl_o, 0);
    rst = 1'b0;
    tick();

    sel = 0;
    push(9'h55);
    tick();
    chk("t55_empty", empty_o, 0);
    chk("t55_level", lvl_o, 1);
    chk("t55_tx_c0", tx_o, 1);
    check_frame(8, 8, 0, 1, 0, 9'h55);
    tick();
    chk("t55_busy_fall", busy_o, 0);
    chk("t55_tx_idle", tx_o, 1);
    chk("t55_empty_end", empty_o, 1);

    sel = 1;
    push(9'h07);
    tick();
    check_frame(8, 8, 1, 1, 0, 9'h07);
    tick();
    chk("even_busy_fall", busy_o, 0);

    sel = 2;
    push(9'h07);
    tick();
    check_frame(8, 8, 2, 1, 0, 9'h07);
    tick();
    chk("odd_busy_fall", busy_o, 0);

    sel = 3;
    push(9'hA5);
    tick();
    push(9'h3C);
    check_frame(8, 8, 0, 2, 4, 9'hA5);
    check_frame(8, 8, 0, 2, 4, 9'h3C);
    tick();
    chk("gap_busy_fall", busy_o, 0);

    sel = 4;
    push(9'h1FF);
    tick();
    check_frame(9, 3, 0, 1, 0, 9'h1FF);
    tick();
    chk("w9_busy_fall", busy_o, 0);

    sel = 0;
    push(9'h00);
    tick();
    tick();
    tick();
    chk("ovf_popped_empty", empty_o, 1);
    for (int i = 0; i < 5; i++) begin
      push(9'(i + 1));
      tick();
      if (i < 4) begin
        chk($sformatf("ovf_level_%0d", i), lvl_o, i + 1);
        chk($sformatf("ovf_quiet_%0d", i), ovf_o, 0);
      end else begin
        chk("ovf_pulse", ovf_o, 1);
        chk("ovf_full", full_o, 1);
        chk("ovf_level_kept", lvl_o, 4);
      end
    end
    tick();
    chk("ovf_pulse_end", ovf_o, 0);
    n = 0;
    for (int j = 0; j < 600; j++) begin
      n += int'(fd_o);
      if (!busy_o && empty_o) break;
      tick();
    end
    chk("ovf_frames", n, 5);
    chk("ovf_drained_busy", busy_o, 0);
    chk("ovf_drained_empty", empty_o, 1);
    tick();

    push(9'h00);
    tick();
    push(9'h00);
    tick();
    push(9'h00);
    tick();
    chk("mid_level", lvl_o, 2);
    for (int j = 0; j < 18; j++) tick();
    chk("mid_tx_data", tx_o, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_tx", tx_o, 1);
    chk("mid_level_clr", lvl_o, 0);
    chk("mid_empty", empty_o, 1);
    chk("mid_busy", busy_o, 0);
    n = 0;
    lows = 0;
    for (int j = 0; j < 200; j++) begin
      tick();
      n += int'(fd_o);
      lows += int'(!tx_o);
    end
    chk("mid_no_frame_done", n, 0);
    chk("mid_no_tx_low", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_frame_gen.md
Name: uart_frame_gen

Overview:
- Synthesizable, parametrised UART frame generator.
- Replaces hand-timed rx bit toggling in SoC benches with a clocked, FIFO-fed serializer.
- Frame format set by parameters: data width, parity, stop bits, bit period.
- Sits beside the SoC top in benches, driving its rx pin; also usable on-chip as a simple UART transmit engine.

Parameters:
- DATA_W, 8, data bits per frame (legal 5..9).
- FIFO_DEPTH, 4, frame queue depth (power of two, >=2).
- CLKS_PER_BIT, 8, clk cycles per serial bit (>=2).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2).
- GAP_CLKS, 0, extra idle-high cycles inserted after each frame's stop bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  DATA_W  frame payload
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  one-cycle pulse: write dropped
- tx  out  1  serial line, idles high
- busy  out  1  high from start bit through end of gap
- frame_done  out  1  one-cycle pulse on the last cycle of the gap (or of the stop bits if GAP_CLKS=0)

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: tx=1, busy=0, frame_done=0, overflow=0, full=0, empty=1, level=0. FIFO pointers cleared, FSM to IDLE.
- Reset asserted mid-frame: tx returns high on the next edge and queued data is discarded.
- FIFO writes:
  - wr_en && !full: write accepted, level increments.
  - wr_en && full: write dropped, overflow pulses the next cycle. full is sampled before any same-cycle pop, so a push to a full FIFO is dropped even if a pop happens that cycle.
  - Simultaneous accepted push and pop: level unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP, GAP.
- IDLE:
  - If !empty at an edge: pop the head into the shift register, tx<=0, busy<=1, go to START.
  - First tx low appears 1 cycle after the data becomes visible in the FIFO.
- Bit timing: each bit holds exactly CLKS_PER_BIT cycles, counted by a baud counter that reloads on every bit change.
- START -> DATA: DATA_W bits, LSB first, counted by a bit counter.
- DATA -> PAR if PARITY != 0, else STOP.
  - Even parity: bit = XOR of data bits.
  - Odd parity: bit = inverted XOR of data bits.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- STOP -> GAP if GAP_CLKS > 0, else end of frame.
- End of frame:
  - frame_done pulses on the final cycle of the frame.
  - The next edge either starts a new frame directly (FIFO non-empty, no idle cycle inserted) or returns to IDLE with busy=0.
- Frame period = (1 + DATA_W + (PARITY!=0) + STOP_BITS)*CLKS_PER_BIT + GAP_CLKS cycles, exact and back-to-back.
- Width rules: level is wide enough to hold FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH. The baud counter is $clog2(CLKS_PER_BIT) bits wide.
- Illegal parameter values trigger an elaboration-time $error.

Decomposition:
- Shared defines file:
  - PARITY_NONE/EVEN/ODD encodings.
  - FSM state encodings.
- Sub-module sync_fifo (DATA_W x FIFO_DEPTH, full/empty/level), reusable elsewhere.
- The serializer FSM stays in uart_frame_gen.

Test Plan:
- Defaults, write 0x55 at cycle 0 -> tx low from cycle 1 for 8 cycles, then 1,0,1,0,1,0,1,0 (8 cycles each), stop high for 8. frame_done pulses at cycle 80; busy falls at cycle 81.
- PARITY=1, write 0x07 -> parity bit 1. PARITY=2, write 0x07 -> parity bit 0. Frame length 88 cycles.
- Write 0xA5 and 0x3C on consecutive cycles, GAP_CLKS=4, STOP_BITS=2 -> second start bit begins exactly 92 cycles after the first; no idle cycle between frames beyond the gap.
- Write 5 bytes in consecutive cycles (FIFO_DEPTH=4) while the first pop is in progress:
  - Only writes that hit full=1 are dropped; overflow pulses once per drop.
  - The total number of frames transmitted equals the number of accepted writes.
- Assert rst for 1 cycle mid-DATA of frame 1 with 2 frames queued -> tx=1 next cycle, level=0, empty=1, no further frames, no frame_done.
- DATA_W=9, CLKS_PER_BIT=3, write 0x1FF -> 9 high data bits of 3 cycles each, frame length 33 cycles.
